// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_scheduler
// Purpose  : Demand-driven round-robin phase scheduler for a four-approach
//            intersection plus pedestrian crossing, with all-red clearance,
//            per-phase watchdog and service/fault flashing modes.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_scheduler #(
  parameter int unsigned SEC     = 10000000,
  parameter int unsigned CLEAR_S = 2,
  parameter int unsigned WDOG_S  = 120
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       service_i,
  input  logic [3:0] car_req_i,
  input  logic       ped_req_i,
  input  logic [3:0] phase_done_i,
  input  logic       ped_done_i,
  output logic [3:0] phase_start_o,
  output logic       ped_start_o,
  output logic [2:0] active_o,
  output logic       all_red_o,
  output logic       service_o,
  output logic       flash_o,
  output logic       fault_o
);

  // Counter reload values; each state counts down to zero inclusive.
  localparam logic [31:0] c_wdog_load  = 32'(WDOG_S * SEC - 1);
  localparam logic [31:0] c_clear_load = 32'(CLEAR_S * SEC - 1);
  localparam logic [31:0] c_flash_load = 32'(SEC - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_PED_START = 3'd3,
    S_PED_WAIT  = 3'd4,
    S_CLEAR     = 3'd5,
    S_SERVICE   = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [1:0]  r_ptr;
  logic [1:0]  r_grant;
  logic        r_last_ped;

  logic        r_svc_s1, r_svc_s2;
  logic [3:0]  r_car_s1, r_car_s2;
  logic        r_ped_s1, r_ped_s2, r_ped_s3;

  logic [3:0]  r_car_pend;
  logic        r_ped_pend;

  logic [3:0]  r_phase_start;
  logic        r_ped_start;
  logic [2:0]  r_active;
  logic        r_all_red;
  logic        r_service;
  logic        r_flash;
  logic        r_fault;

  logic [1:0]  w_grant;
  logic        w_any;
  logic        w_ped_rise;

  assign w_ped_rise = r_ped_s2 & ~r_ped_s3;
  assign w_any      = |r_car_pend;

  // Two-flop synchronizers for the asynchronous level inputs, plus a third
  // pedestrian stage for rising-edge detection.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_svc_s1 <= 1'b0;
      r_svc_s2 <= 1'b0;
      r_car_s1 <= '0;
      r_car_s2 <= '0;
      r_ped_s1 <= 1'b0;
      r_ped_s2 <= 1'b0;
      r_ped_s3 <= 1'b0;
    end else begin
      r_svc_s1 <= service_i;
      r_svc_s2 <= r_svc_s1;
      r_car_s1 <= car_req_i;
      r_car_s2 <= r_car_s1;
      r_ped_s1 <= ped_req_i;
      r_ped_s2 <= r_ped_s1;
      r_ped_s3 <= r_ped_s2;
    end
  end

  // Round-robin search: first pending approach at or after the pointer.
  always_comb begin
    w_grant = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (r_car_pend[r_ptr + 2'(k)]) w_grant = r_ptr + 2'(k);
    end
  end

  // Demand latches; a clear issued by a start takes precedence over a set.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_car_pend <= '0;
      r_ped_pend <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if ((r_state == S_START) && (r_grant == 2'(i))) begin
          r_car_pend[i] <= 1'b0;
        end else if (r_car_s2[i] && !((r_state == S_WAIT_DONE) && (r_grant == 2'(i)))) begin
          r_car_pend[i] <= 1'b1;
        end
      end
      if (r_state == S_PED_START) begin
        r_ped_pend <= 1'b0;
      end else if (w_ped_rise && (r_state != S_PED_WAIT)) begin
        r_ped_pend <= 1'b1;
      end
    end
  end

  // Phase sequencer with registered outputs; start pulses default low.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_ptr         <= 2'd0;
      r_grant       <= 2'd0;
      r_last_ped    <= 1'b0;
      r_phase_start <= '0;
      r_ped_start   <= 1'b0;
      r_active      <= 3'd5;
      r_all_red     <= 1'b1;
      r_service     <= 1'b0;
      r_flash       <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_phase_start <= '0;
      r_ped_start   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_svc_s2) begin
            r_state   <= S_SERVICE;
            r_active  <= 3'd6;
            r_all_red <= 1'b0;
            r_service <= 1'b1;
            r_flash   <= 1'b0;
            r_cnt     <= c_flash_load;
          end else if (r_ped_pend && !r_last_ped) begin
            r_state     <= S_PED_START;
            r_ped_start <= 1'b1;
            r_active    <= 3'd4;
            r_all_red   <= 1'b0;
            r_last_ped  <= 1'b1;
          end else if (w_any) begin
            r_state       <= S_START;
            r_grant       <= w_grant;
            r_ptr         <= w_grant + 2'd1;
            r_phase_start <= 4'b0001 << w_grant;
            r_active      <= {1'b0, w_grant};
            r_all_red     <= 1'b0;
            r_last_ped    <= 1'b0;
          end
        end
        S_START: begin
          r_state <= S_WAIT_DONE;
          r_cnt   <= c_wdog_load;
        end
        S_PED_START: begin
          r_state <= S_PED_WAIT;
          r_cnt   <= c_wdog_load;
        end
        S_WAIT_DONE, S_PED_WAIT: begin
          // A completion in the same cycle the watchdog expires is honoured.
          if ((r_state == S_WAIT_DONE) ? phase_done_i[r_grant] : ped_done_i) begin
            r_state   <= S_CLEAR;
            r_cnt     <= c_clear_load;
            r_active  <= 3'd5;
            r_all_red <= 1'b1;
          end else if (r_cnt == 32'd0) begin
            r_state   <= S_FAULT;
            r_active  <= 3'd7;
            r_service <= 1'b1;
            r_fault   <= 1'b1;
            r_flash   <= 1'b0;
            r_cnt     <= c_flash_load;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_CLEAR: begin
          if (r_cnt == 32'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_SERVICE: begin
          if (!r_svc_s2) begin
            // Leaving maintenance restarts the rotation from East.
            r_state   <= S_CLEAR;
            r_ptr     <= 2'd0;
            r_cnt     <= c_clear_load;
            r_active  <= 3'd5;
            r_all_red <= 1'b1;
            r_service <= 1'b0;
            r_flash   <= 1'b0;
          end else if (r_cnt == 32'd0) begin
            r_flash <= ~r_flash;
            r_cnt   <= c_flash_load;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_FAULT: begin
          if (r_cnt == 32'd0) begin
            r_flash <= ~r_flash;
            r_cnt   <= c_flash_load;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign phase_start_o = r_phase_start;
  assign ped_start_o   = r_ped_start;
  assign active_o      = r_active;
  assign all_red_o     = r_all_red;
  assign service_o     = r_service;
  assign flash_o       = r_flash;
  assign fault_o       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_scheduler
// Purpose  : Self-checking bench for traffic_phase_scheduler (SEC=10,
//            CLEAR_S=1, WDOG_S=5): table of grant steps plus directed
//            fault, service, watchdog-race and async-reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_scheduler;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       service_i;
  logic [3:0] car_req_i;
  logic       ped_req_i;
  logic [3:0] phase_done_i;
  logic       ped_done_i;
  logic [3:0] phase_start_o;
  logic       ped_start_o;
  logic [2:0] active_o;
  logic       all_red_o;
  logic       service_o;
  logic       flash_o;
  logic       fault_o;

  traffic_phase_scheduler #(.SEC(10), .CLEAR_S(1), .WDOG_S(5)) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .service_i    (service_i),
    .car_req_i    (car_req_i),
    .ped_req_i    (ped_req_i),
    .phase_done_i (phase_done_i),
    .ped_done_i   (ped_done_i),
    .phase_start_o(phase_start_o),
    .ped_start_o  (ped_start_o),
    .active_o     (active_o),
    .all_red_o    (all_red_o),
    .service_o    (service_o),
    .flash_o      (flash_o),
    .fault_o      (fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         rst;
    logic [3:0] car;
    bit         ped_press;
    bit         bad_done;
    int         done_dly;
    logic [3:0] exp_start;
    logic       exp_ped;
    logic [2:0] exp_act;
    int         exp_lat;
  } vec_t;

  vec_t tbl [11];
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat;
  bit   found;
  bit   red_ok;
  bit   quiet_ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n_i    = 1'b0;
    service_i    = 1'b0;
    car_req_i    = '0;
    ped_req_i    = 1'b0;
    phase_done_i = '0;
    ped_done_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  // Waits for any start pulse; while waiting the lights must be all-red/none.
  task automatic wait_start(input int budget, output int l, output bit f, output bit r);
    l = 0;
    f = 1'b0;
    r = 1'b1;
    while (!f && (l < budget)) begin
      @(negedge clk_i);
      l++;
      if ((phase_start_o != 4'b0000) || ped_start_o) f = 1'b1;
      else if (!all_red_o || (active_o != 3'd5)) r = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got stuck, expected completion");
    $fatal(1);
  end

  initial begin
    //           rst  car      ped  bad  dly start    ped   act   lat
    tbl[0]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 3, 4'b0100, 1'b0, 3'd2, 4};
    tbl[1]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 3, 4'b0100, 1'b0, 3'd2, 11};
    tbl[2]  = '{1'b1, 4'b1011, 1'b0, 1'b0, 3, 4'b0001, 1'b0, 3'd0, 4};
    tbl[3]  = '{1'b0, 4'b1011, 1'b0, 1'b0, 3, 4'b0010, 1'b0, 3'd1, 11};
    tbl[4]  = '{1'b0, 4'b1011, 1'b0, 1'b0, 3, 4'b1000, 1'b0, 3'd3, 11};
    tbl[5]  = '{1'b0, 4'b1011, 1'b0, 1'b0, 3, 4'b0001, 1'b0, 3'd0, 11};
    tbl[6]  = '{1'b0, 4'b1011, 1'b0, 1'b0, 3, 4'b0010, 1'b0, 3'd1, 11};
    tbl[7]  = '{1'b1, 4'b0001, 1'b1, 1'b0, 3, 4'b0001, 1'b0, 3'd0, 4};
    tbl[8]  = '{1'b0, 4'b0001, 1'b1, 1'b1, 8, 4'b0000, 1'b1, 3'd4, 11};
    tbl[9]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 3, 4'b0001, 1'b0, 3'd0, 11};
    tbl[10] = '{1'b0, 4'b0001, 1'b0, 1'b0, 3, 4'b0001, 1'b0, 3'd0, 11};

    do_reset();
    reset_n_i = 1'b0;
    @(negedge clk_i);
    check("rst active", 32'(active_o), 32'd5);
    check("rst all_red", 32'(all_red_o), 32'd1);
    check("rst starts", 32'({phase_start_o, ped_start_o}), 32'd0);
    check("rst service/flash/fault", 32'({service_o, flash_o, fault_o}), 32'd0);

    // Table of grant steps.
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) do_reset();
      car_req_i = tbl[i].car;
      wait_start(40, lat, found, red_ok);
      check($sformatf("vec%0d start_seen", i), 32'(found), 32'd1);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("vec%0d all_red_wait", i), 32'(red_ok), 32'd1);
      check($sformatf("vec%0d start_vec", i), 32'({phase_start_o, ped_start_o}),
            32'({tbl[i].exp_start, tbl[i].exp_ped}));
      check($sformatf("vec%0d active", i), 32'(active_o), 32'(tbl[i].exp_act));
      @(negedge clk_i);
      check($sformatf("vec%0d pulse_width", i), 32'({phase_start_o, ped_start_o}), 32'd0);
      check($sformatf("vec%0d active_hold", i), 32'(active_o), 32'(tbl[i].exp_act));
      ped_req_i = tbl[i].ped_press;
      if (tbl[i].bad_done) phase_done_i = ~tbl[i].exp_start;
      @(negedge clk_i);
      phase_done_i = '0;
      @(negedge clk_i);
      ped_req_i = 1'b0;
      for (int c = 3; c < tbl[i].done_dly; c++) @(negedge clk_i);
      if (tbl[i].exp_ped) ped_done_i = 1'b1;
      else phase_done_i = tbl[i].exp_start;
      @(negedge clk_i);
      ped_done_i   = 1'b0;
      phase_done_i = '0;
    end

    // Done in the same cycle the watchdog reaches zero: done wins.
    do_reset();
    car_req_i = 4'b0001;
    wait_start(40, lat, found, red_ok);
    check("race start_seen", 32'(found), 32'd1);
    car_req_i = '0;
    repeat (50) @(negedge clk_i);
    phase_done_i = 4'b0001;
    @(negedge clk_i);
    phase_done_i = '0;
    check("race fault", 32'(fault_o), 32'd0);
    check("race active", 32'(active_o), 32'd5);

    // Watchdog fault, flashing, stickiness, async reset recovery.
    do_reset();
    car_req_i = 4'b0001;
    wait_start(40, lat, found, red_ok);
    check("wdog start_vec", 32'(phase_start_o), 32'b0001);
    quiet_ok = 1'b1;
    for (int j = 1; j <= 71; j++) begin
      @(negedge clk_i);
      if ((phase_start_o != 4'b0000) || ped_start_o) quiet_ok = 1'b0;
      if (j == 50) begin
        check("wdog pre fault", 32'(fault_o), 32'd0);
        check("wdog pre active", 32'(active_o), 32'd0);
      end
      if (j == 51) begin
        check("wdog fault", 32'(fault_o), 32'd1);
        check("wdog active", 32'(active_o), 32'd7);
        check("wdog service_o", 32'(service_o), 32'd1);
      end
      if (j == 55) service_i = 1'b1;
      if (j == 56) phase_done_i = 4'b0001;
      if (j == 57) phase_done_i = '0;
      if (j == 60) check("wdog flash j60", 32'(flash_o), 32'd0);
      if (j == 61) check("wdog flash j61", 32'(flash_o), 32'd1);
      if (j == 70) check("wdog flash j70", 32'(flash_o), 32'd1);
      if (j == 71) check("wdog flash j71", 32'(flash_o), 32'd0);
    end
    check("wdog no starts", 32'(quiet_ok), 32'd1);
    service_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("wdog sticky fault", 32'(fault_o), 32'd1);
    check("wdog sticky active", 32'(active_o), 32'd7);
    #2 reset_n_i = 1'b0;
    #1;
    check("wdog rst fault", 32'(fault_o), 32'd0);
    check("wdog rst active", 32'(active_o), 32'd5);
    check("wdog rst outs", 32'({all_red_o, service_o, flash_o}), 32'b100);

    // Service requested mid-phase, then released: restart from East.
    do_reset();
    car_req_i = 4'b0010;
    wait_start(40, lat, found, red_ok);
    check("svc start_vec", 32'(phase_start_o), 32'b0010);
    quiet_ok = 1'b1;
    for (int j = 1; j <= 36; j++) begin
      @(negedge clk_i);
      if (j == 1) service_i = 1'b1;
      if (j == 4) phase_done_i = 4'b0010;
      if (j == 5) phase_done_i = '0;
      if ((j > 1) && ((phase_start_o != 4'b0000) || ped_start_o)) quiet_ok = 1'b0;
      if (j == 15) check("svc idle active", 32'(active_o), 32'd5);
      if (j == 16) begin
        check("svc active", 32'(active_o), 32'd6);
        check("svc service_o", 32'(service_o), 32'd1);
        car_req_i = 4'b1111;
      end
      if (j == 25) check("svc flash j25", 32'(flash_o), 32'd0);
      if (j == 26) check("svc flash j26", 32'(flash_o), 32'd1);
    end
    check("svc no starts", 32'(quiet_ok), 32'd1);
    service_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("svc still active", 32'(active_o), 32'd6);
    @(negedge clk_i);
    check("svc exit active", 32'(active_o), 32'd5);
    check("svc exit outs", 32'({all_red_o, service_o, flash_o}), 32'b100);
    wait_start(40, lat, found, red_ok);
    check("svc restart latency", 32'(lat), 32'd11);
    check("svc restart red", 32'(red_ok), 32'd1);
    check("svc restart east", 32'(phase_start_o), 32'b0001);

    // Asynchronous reset mid WAIT_DONE; a late done must not start anything.
    do_reset();
    car_req_i = 4'b0001;
    wait_start(40, lat, found, red_ok);
    check("arst start_seen", 32'(found), 32'd1);
    car_req_i = '0;
    repeat (2) @(negedge clk_i);
    #2 reset_n_i = 1'b0;
    #1;
    check("arst active", 32'(active_o), 32'd5);
    check("arst all_red", 32'(all_red_o), 32'd1);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    phase_done_i = 4'b0001;
    @(negedge clk_i);
    phase_done_i = '0;
    wait_start(20, lat, found, red_ok);
    check("arst no start", 32'(found), 32'd0);
    check("arst stays red", 32'(red_ok), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
